// File: rtl/if_fetch_if.sv
// if_fetch_if: fetch-side handshake bundle.
// Carries the instruction-memory read port and the decode output port.
interface if_fetch_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [ADDR_W-1:0] imem_req_addr;
    logic              imem_rsp_valid;
    logic [DATA_W-1:0] imem_rsp_data;
    logic              inst_valid;
    logic              inst_ready;
    logic [DATA_W-1:0] inst_data;
    logic [ADDR_W-1:0] inst_pc;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data,
        output inst_valid,
        output inst_data,
        output inst_pc,
        input  inst_ready
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data,
        input  inst_valid,
        input  inst_data,
        input  inst_pc,
        output inst_ready
    );
endinterface

// File: rtl/if_fetch.sv
// if_fetch: single-outstanding instruction fetch with a small return buffer.
// Optional IF_MISALIGN_CHK_EN adds a sticky misaligned-PC error output.
module if_fetch #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] pc_addr,
    output logic              pc_stall,
    input  logic              flush,
`ifdef IF_MISALIGN_CHK_EN
    output logic              misalign_err,
`endif
    if_fetch_if.master        bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] pend_pc;
    logic [ADDR_W-1:0] buf_pc   [DEPTH];
    logic [DATA_W-1:0] buf_data [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     used;

    logic              idle;
    logic              has_room;
    logic              addr_ok;
    logic [ADDR_W-1:0] fetch_addr;
    logic              req_fire;
    logic              push;
    logic              pop;

    assign idle     = (state == IDLE);
    // A request only issues from IDLE with a free slot, and nothing else
    // can push while it is pending, so the response always has room.
    assign has_room = (used < FULL);

`ifdef IF_MISALIGN_CHK_EN
    assign addr_ok    = (pc_addr[1:0] == 2'b00);
    assign fetch_addr = pc_addr;
`else
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);
    assign addr_ok    = 1'b1;
    assign fetch_addr = pc_addr & ALIGN_MASK;
`endif

    assign bus.imem_req_valid = rst_n & idle & has_room & ~flush & addr_ok;
    assign bus.imem_req_addr  = rst_n ? fetch_addr : '0;
    assign req_fire           = bus.imem_req_valid & bus.imem_req_ready;
    assign pc_stall           = ~req_fire;

    assign push = (state == WAIT) & bus.imem_rsp_valid & ~flush;
    assign pop  = bus.inst_valid & bus.inst_ready;

    assign bus.inst_valid = (used != '0);
    assign bus.inst_data  = buf_data[rd_ptr];
    assign bus.inst_pc    = buf_pc[rd_ptr];

    // Request/response sequencing; a flushed pending read becomes DROP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pend_pc <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_fire) begin
                        state   <= WAIT;
                        pend_pc <= fetch_addr;
                    end
                end
                WAIT: begin
                    if (bus.imem_rsp_valid) begin
                        state <= IDLE;
                    end else if (flush) begin
                        state <= DROP;
                    end
                end
                DROP: begin
                    if (bus.imem_rsp_valid) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Return buffer: circular FIFO, emptied wholesale on flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            used   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                buf_pc[i]   <= '0;
                buf_data[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            used   <= '0;
        end else begin
            if (push) begin
                buf_pc[wr_ptr]   <= pend_pc;
                buf_data[wr_ptr] <= bus.imem_rsp_data;
                wr_ptr           <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   used <= used + CW'(1);
                2'b01:   used <= used - CW'(1);
                default: used <= used;
            endcase
        end
    end

`ifdef IF_MISALIGN_CHK_EN
    // Sticky misaligned-PC flag; a redirect clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_err <= 1'b0;
        end else if (flush) begin
            misalign_err <= 1'b0;
        end else if (idle && !addr_ok) begin
            misalign_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: directed scenarios plus random traffic for if_fetch.
// A queue-level model predicts every output each cycle.
module tb_if_fetch;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 2;

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [DW-1:0] d;
    } ent_t;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic [AW-1:0] pc_addr  = '0;
    logic          flush    = 1'b0;
    logic          pc_stall;
`ifdef IF_MISALIGN_CHK_EN
    logic          misalign_err;
`endif

    if_fetch_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    if_fetch #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .pc_addr(pc_addr),
        .pc_stall(pc_stall),
        .flush(flush),
`ifdef IF_MISALIGN_CHK_EN
        .misalign_err(misalign_err),
`endif
        .bus(bus.master)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int fire_cnt = 0;
    bit fire_q = 1'b0;
    bit pc_auto = 1'b0;

    // memory stub
    bit            mem_busy = 1'b0;
    int            mem_lat  = 0;
    int            lat_cfg  = 1;
    logic [AW-1:0] mem_addr = '0;
    logic          nxt_rv   = 1'b0;
    logic [DW-1:0] nxt_rd   = '0;

    // reference model
    ent_t          mq[$];
    bit            m_out  = 1'b0;
    bit            m_drop = 1'b0;
    bit            m_err  = 1'b0;
    logic [AW-1:0] m_pend = '0;

    // delivery log
    logic [AW-1:0] lpc[$];
    logic [DW-1:0] ld[$];
    int            lcyc[$];

    function automatic logic [AW-1:0] al(input logic [AW-1:0] a);
`ifdef IF_MISALIGN_CHK_EN
        return a;
`else
        return {a[AW-1:2], 2'b00};
`endif
    endfunction

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [AW-1:0] get_pc(input int i);
        return (i < lpc.size()) ? lpc[i] : '1;
    endfunction

    function automatic logic [DW-1:0] get_d(input int i);
        return (i < ld.size()) ? ld[i] : '1;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)",
                     nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_out  = 1'b0;
        m_drop = 1'b0;
        m_err  = 1'b0;
        m_pend = '0;
    endtask

    // Compare, then advance model and memory stub for the coming edge.
    always @(negedge clk) begin
        logic e_rv;
        bit   pop;
        bit   got;
        bit   fire;
        ent_t e;
        cyc++;
        if (!rst_n) model_clear();
        e_rv = rst_n && !m_out && !m_drop && (mq.size() < DEPTH) && !flush;
`ifdef IF_MISALIGN_CHK_EN
        if (pc_addr[1:0] != 2'b00) e_rv = 1'b0;
`endif
        chk("req_valid", bus.imem_req_valid, e_rv);
        chk("pc_stall", pc_stall, !(e_rv && bus.imem_req_ready));
        if (e_rv || !rst_n)
            chk("req_addr", bus.imem_req_addr, rst_n ? al(pc_addr) : '0);
        chk("inst_valid", bus.inst_valid, mq.size() != 0);
        if (mq.size() != 0) begin
            chk("inst_pc", bus.inst_pc, mq[0].pc);
            chk("inst_data", bus.inst_data, mq[0].d);
        end else if (!rst_n) begin
            chk("rst_inst_pc", bus.inst_pc, 0);
            chk("rst_inst_data", bus.inst_data, 0);
        end
`ifdef IF_MISALIGN_CHK_EN
        chk("misalign_err", misalign_err, m_err);
`endif
        if (rst_n && bus.inst_valid && bus.inst_ready) begin
            lpc.push_back(bus.inst_pc);
            ld.push_back(bus.inst_data);
            lcyc.push_back(cyc);
        end
        if (rst_n) begin
            pop = (mq.size() != 0) && bus.inst_ready;
            got = (m_out || m_drop) && bus.imem_rsp_valid;
            if (flush) begin
                mq.delete();
            end else begin
                if (pop) void'(mq.pop_front());
                if (got && m_out) begin
                    e.pc = m_pend;
                    e.d  = mem_word(m_pend);
                    mq.push_back(e);
                end
            end
`ifdef IF_MISALIGN_CHK_EN
            if (flush) m_err = 1'b0;
            else if (!m_out && !m_drop && pc_addr[1:0] != 2'b00) m_err = 1'b1;
`endif
            if (got) begin
                m_out  = 1'b0;
                m_drop = 1'b0;
            end else if (m_out && flush) begin
                m_out  = 1'b0;
                m_drop = 1'b1;
            end
            if (e_rv && bus.imem_req_ready) begin
                m_out  = 1'b1;
                m_pend = al(pc_addr);
            end
        end
        fire = bus.imem_req_valid && bus.imem_req_ready;
        fire_q = fire;
        if (fire && rst_n) fire_cnt++;
        nxt_rv = 1'b0;
        nxt_rd = DW'($urandom);
        if (fire) begin
            mem_busy = 1'b1;
            mem_addr = bus.imem_req_addr;
            mem_lat  = (lat_cfg == 0) ? int'($urandom_range(1, 4)) - 1
                                      : lat_cfg - 1;
        end else if (mem_busy) begin
            mem_lat--;
        end
        if (mem_busy && mem_lat <= 0) begin
            nxt_rv   = 1'b1;
            nxt_rd   = mem_word(mem_addr);
            mem_busy = 1'b0;
        end
    end

    // Memory stub drives its response just after the edge.
    always @(posedge clk) begin
        bus.imem_rsp_valid <= nxt_rv;
        bus.imem_rsp_data  <= nxt_rd;
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (pc_auto && fire_q) pc_addr = pc_addr + 32'd4;
    endtask

    task automatic wait_fire(input string nm);
        int n = 0;
        do begin
            step();
            n++;
        end while (!fire_q && n < 50);
        chk(nm, fire_q, 1);
    endtask

    task automatic wait_deliver(input int cnt, input string nm);
        int n = 0;
        while (lpc.size() < cnt && n < 200) begin
            step();
            n++;
        end
        chk(nm, lpc.size() >= cnt, 1);
    endtask

    task automatic reset_clean();
        int n = 0;
        bus.imem_req_ready = 1'b0;
        flush   = 1'b0;
        pc_auto = 1'b0;
        while (mem_busy && n < 20) begin
            step();
            n++;
        end
        step();
        rst_n = 1'b0;
        step();
        step();
        lpc.delete();
        ld.delete();
        lcyc.delete();
        fire_cnt = 0;
    endtask

    initial begin
        bit saw;
        bus.imem_req_ready = 1'b0;
        bus.inst_ready     = 1'b0;
        repeat (3) step();
        chk("rst_req_valid", bus.imem_req_valid, 0);
        chk("rst_pc_stall", pc_stall, 1);
        chk("rst_inst_valid", bus.inst_valid, 0);

        // streaming
        pc_addr = 32'h0; lat_cfg = 1; pc_auto = 1;
        bus.imem_req_ready = 1'b1; bus.inst_ready = 1'b1;
        rst_n = 1'b1;
        wait_deliver(3, "s_count");
        chk("s_pc0", get_pc(0), 32'h0);
        chk("s_pc1", get_pc(1), 32'h4);
        chk("s_pc2", get_pc(2), 32'h8);
        chk("s_d0", get_d(0), 32'h1357_9BDF);
        chk("s_d1", get_d(1), 32'h1357_9BDB);
        chk("s_d2", get_d(2), 32'h1357_9BD7);
        if (lcyc.size() >= 3) begin
            chk("s_gap1", lcyc[1] - lcyc[0], 2);
            chk("s_gap2", lcyc[2] - lcyc[1], 2);
        end

        // backpressure
        reset_clean();
        pc_addr = 32'h0; lat_cfg = 1; pc_auto = 1;
        bus.inst_ready = 1'b0; bus.imem_req_ready = 1'b1;
        rst_n = 1'b1;
        repeat (10) step();
        chk("bp_fires", fire_cnt, 2);
        chk("bp_inst_valid", bus.inst_valid, 1);
        chk("bp_req_valid", bus.imem_req_valid, 0);
        chk("bp_pc_stall", pc_stall, 1);
        chk("bp_head", bus.inst_pc, 32'h0);
        bus.inst_ready = 1'b1;
        wait_deliver(3, "bp_drain");
        chk("bp_pc0", get_pc(0), 32'h0);
        chk("bp_pc1", get_pc(1), 32'h4);
        chk("bp_pc2", get_pc(2), 32'h8);

        // flush while waiting
        reset_clean();
        pc_addr = 32'h10; pc_auto = 0; lat_cfg = 4;
        bus.inst_ready = 1'b1; bus.imem_req_ready = 1'b1;
        rst_n = 1'b1;
        wait_fire("fw_fire");
        flush = 1'b1; pc_addr = 32'h100;
        step();
        flush = 1'b0; pc_auto = 1; lat_cfg = 1;
        wait_deliver(1, "fw_deliver");
        chk("fw_pc", get_pc(0), 32'h100);
        chk("fw_data", get_d(0), 32'h1357_9ADF);

        // flush coincident with a response, buffer holding 0x20
        reset_clean();
        pc_addr = 32'h20; pc_auto = 1; lat_cfg = 1;
        bus.inst_ready = 1'b0; bus.imem_req_ready = 1'b1;
        rst_n = 1'b1;
        saw = 1'b0;
        for (int i = 0; i < 20 && !saw; i++) begin
            step();
            saw = bus.inst_valid;
        end
        chk("fc_buffered", saw, 1);
        chk("fc_head", bus.inst_pc, 32'h20);
        lat_cfg = 3;
        saw = 1'b0;
        for (int i = 0; i < 20 && !saw; i++) begin
            step();
            saw = bus.imem_rsp_valid;
        end
        chk("fc_rsp_seen", saw, 1);
        flush = 1'b1; pc_addr = 32'h200;
        step();
        flush = 1'b0;
        chk("fc_inst_valid", bus.inst_valid, 0);
        lat_cfg = 1; bus.inst_ready = 1'b1;
        wait_deliver(1, "fc_deliver");
        chk("fc_pc", get_pc(0), 32'h200);

        // async reset in WAIT, then a stale response
        reset_clean();
        pc_addr = 32'h0; pc_auto = 0; lat_cfg = 5;
        bus.inst_ready = 1'b1; bus.imem_req_ready = 1'b1;
        rst_n = 1'b1;
        wait_fire("rw_fire");
        bus.imem_req_ready = 1'b0;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        saw = 1'b0;
        for (int i = 0; i < 10 && !saw; i++) begin
            step();
            saw = bus.imem_rsp_valid;
        end
        chk("rw_stale_seen", saw, 1);
        step();
        chk("rw_inst_valid", bus.inst_valid, 0);
        lat_cfg = 1; pc_auto = 1; bus.imem_req_ready = 1'b1;
        wait_deliver(1, "rw_deliver");
        chk("rw_pc", get_pc(0), 32'h0);
        chk("rw_data", get_d(0), 32'h1357_9BDF);

        // misaligned PC
        reset_clean();
        pc_addr = 32'h6; pc_auto = 0; lat_cfg = 1;
        bus.inst_ready = 1'b1; bus.imem_req_ready = 1'b1;
        rst_n = 1'b1;
`ifdef IF_MISALIGN_CHK_EN
        repeat (3) step();
        chk("ma_req_valid", bus.imem_req_valid, 0);
        chk("ma_err", misalign_err, 1);
        chk("ma_stall", pc_stall, 1);
        flush = 1'b1; pc_addr = 32'h8;
        step();
        flush = 1'b0; pc_auto = 1;
        chk("ma_err_clr", misalign_err, 0);
        wait_deliver(1, "ma_deliver");
        chk("ma_pc", get_pc(0), 32'h8);
`else
        wait_deliver(1, "ma_deliver");
        chk("ma_pc", get_pc(0), 32'h4);
        chk("ma_data", get_d(0), 32'h1357_9BDB);
`endif

        // random traffic
        reset_clean();
        pc_addr = 32'h0; pc_auto = 1; lat_cfg = 0;
        rst_n = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            bus.imem_req_ready = ($urandom_range(0, 3) != 0);
            bus.inst_ready     = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 15) == 0) begin
                flush   = 1'b1;
                pc_addr = ($urandom & 32'h0000_FFFC);
                if ($urandom_range(0, 3) == 0)
                    pc_addr[1:0] = 2'($urandom_range(1, 3));
            end else begin
                flush = 1'b0;
            end
            step();
        end
        flush = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
